// File: rtl/mem_arbiter_if.sv
// Bundle of the two master ports and the shared memory port of mem_arbiter.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              m0_req;
  logic              m0_write;
  logic [XLEN/8-1:0] m0_wstrb;
  logic [XLEN-1:0]   m0_addr;
  logic [XLEN-1:0]   m0_wdata;
  logic              m0_ready;
  logic              m0_rvalid;
  logic [XLEN-1:0]   m0_rdata;

  logic              m1_req;
  logic              m1_write;
  logic [XLEN/8-1:0] m1_wstrb;
  logic [XLEN-1:0]   m1_addr;
  logic [XLEN-1:0]   m1_wdata;
  logic              m1_ready;
  logic              m1_rvalid;
  logic [XLEN-1:0]   m1_rdata;

  logic              s_req;
  logic              s_write;
  logic [XLEN/8-1:0] s_wstrb;
  logic [XLEN-1:0]   s_addr;
  logic [XLEN-1:0]   s_wdata;
  logic              s_ready;
  logic              s_rvalid;
  logic [XLEN-1:0]   s_rdata;

  logic              err;

  modport slave (
    input  m0_req, m0_write, m0_wstrb, m0_addr, m0_wdata,
    output m0_ready, m0_rvalid, m0_rdata,
    input  m1_req, m1_write, m1_wstrb, m1_addr, m1_wdata,
    output m1_ready, m1_rvalid, m1_rdata,
    output s_req, s_write, s_wstrb, s_addr, s_wdata,
    input  s_ready, s_rvalid, s_rdata,
    output err
  );

  modport master (
    output m0_req, m0_write, m0_wstrb, m0_addr, m0_wdata,
    input  m0_ready, m0_rvalid, m0_rdata,
    output m1_req, m1_write, m1_wstrb, m1_addr, m1_wdata,
    input  m1_ready, m1_rvalid, m1_rdata,
    input  s_req, s_write, s_wstrb, s_addr, s_wdata,
    output s_ready, s_rvalid, s_rdata,
    input  err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto one memory port; read responses are routed back
// in issue order through an ID FIFO of up to DEPTH outstanding reads.
module mem_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_b,
  mem_arbiter_if.slave  bus
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic            rr_pref_r;
  logic [CNTW-1:0] count_r;
  logic [PTRW-1:0] wptr_r;
  logic [PTRW-1:0] rptr_r;
  logic            id_mem_r [DEPTH];
  logic            err_r;

  logic              gnt_s;
  logic              gnt_req_s;
  logic              gnt_write_s;
  logic [XLEN/8-1:0] gnt_wstrb_s;
  logic [XLEN-1:0]   gnt_addr_s;
  logic [XLEN-1:0]   gnt_wdata_s;
  logic              full_s;
  logic              empty_s;
  logic              s_req_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              head_s;

  // pref names the master that wins a tie (the one not served by the last transfer)
  function automatic logic rr_pick(input logic req0, input logic req1, input logic pref);
    logic pick;
    if (req0 && req1) begin
      pick = pref;
    end else if (req1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

  // Grant selection, request mux and FIFO handshake qualifiers
  always_comb begin
    gnt_s   = rr_pick(bus.m0_req, bus.m1_req, rr_pref_r);
    full_s  = (count_r == FULL_CNT);
    empty_s = (count_r == {CNTW{1'b0}});
    if (gnt_s) begin
      gnt_req_s   = bus.m1_req;
      gnt_write_s = bus.m1_write;
      gnt_wstrb_s = bus.m1_wstrb;
      gnt_addr_s  = bus.m1_addr;
      gnt_wdata_s = bus.m1_wdata;
    end else begin
      gnt_req_s   = bus.m0_req;
      gnt_write_s = bus.m0_write;
      gnt_wstrb_s = bus.m0_wstrb;
      gnt_addr_s  = bus.m0_addr;
      gnt_wdata_s = bus.m0_wdata;
    end
    // full is taken from the registered count only; a pop this cycle does not unblock a read
    s_req_s  = gnt_req_s && !(!gnt_write_s && full_s);
    accept_s = s_req_s && bus.s_ready;
    push_s   = accept_s && !gnt_write_s;
    pop_s    = bus.s_rvalid && !empty_s;
    head_s   = id_mem_r[rptr_r];
  end

  assign bus.s_req     = s_req_s;
  assign bus.s_write   = gnt_write_s;
  assign bus.s_wstrb   = gnt_wstrb_s;
  assign bus.s_addr    = gnt_addr_s;
  assign bus.s_wdata   = gnt_wdata_s;
  assign bus.m0_ready  = accept_s && !gnt_s;
  assign bus.m1_ready  = accept_s && gnt_s;
  assign bus.m0_rvalid = pop_s && !head_s;
  assign bus.m1_rvalid = pop_s && head_s;
  assign bus.m0_rdata  = bus.s_rdata;
  assign bus.m1_rdata  = bus.s_rdata;
  assign bus.err       = err_r;

  // Round-robin pointer, ID FIFO and sticky error state
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      rr_pref_r <= 1'b0;
      count_r   <= {CNTW{1'b0}};
      wptr_r    <= {PTRW{1'b0}};
      rptr_r    <= {PTRW{1'b0}};
      err_r     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        id_mem_r[i] <= 1'b0;
      end
    end else begin
      if (accept_s) begin
        rr_pref_r <= ~gnt_s;
      end
      if (push_s) begin
        id_mem_r[wptr_r] <= gnt_s;
        wptr_r           <= wptr_r + 1'b1;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (bus.s_rvalid && empty_s) begin
        err_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected accepts/responses into queues,
// a negedge monitor pops and compares whenever the arbiter shows ready or rvalid.
module tb_mem_arbiter;
  typedef struct packed {
    logic        id;
    logic        wr;
    logic [31:0] addr;
  } acc_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic rst_b;
  int   n_chk;
  int   n_fail;
  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  acc_t mon_a;
  rsp_t mon_r;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_a(input logic id, input logic wr, input logic [31:0] addr);
    acc_t a;
    a.id = id; a.wr = wr; a.addr = addr;
    exp_acc.push_back(a);
  endtask

  task automatic exp_r(input logic id, input logic [31:0] data);
    rsp_t r;
    r.id = id; r.data = data;
    exp_rsp.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
  endtask

  task automatic drive_m(input int m, input logic req, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_write = wr; bus.m0_addr = addr; bus.m0_wdata = wdata;
      bus.m0_wstrb = 4'hF;
    end else begin
      bus.m1_req = req; bus.m1_write = wr; bus.m1_addr = addr; bus.m1_wdata = wdata;
      bus.m1_wstrb = 4'hF;
    end
  endtask

  task automatic respond(input logic [31:0] data);
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = data;
    step();
    bus.s_rvalid = 1'b0;
    bus.s_rdata  = 32'd0;
  endtask

  // Scoreboard monitor: compare every accept and every routed response against the queues
  always @(negedge clk) begin
    if (bus.m0_ready || bus.m1_ready) begin
      chk_b("acc_one_ready", bus.m0_ready && bus.m1_ready, 1'b0);
      chk_b("acc_s_req", bus.s_req, 1'b1);
      if (exp_acc.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL acc_unexpected: got accept of m%0d addr %h expected none", bus.m1_ready, bus.s_addr);
      end else begin
        mon_a = exp_acc.pop_front();
        chk_b("acc_id", bus.m1_ready, mon_a.id);
        chk_b("acc_write", bus.s_write, mon_a.wr);
        chk_w("acc_addr", bus.s_addr, mon_a.addr);
      end
    end
    if (bus.m0_rvalid || bus.m1_rvalid) begin
      chk_b("rsp_one_valid", bus.m0_rvalid && bus.m1_rvalid, 1'b0);
      if (exp_rsp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_unexpected: got response to m%0d expected none", bus.m1_rvalid);
      end else begin
        mon_r = exp_rsp.pop_front();
        chk_b("rsp_id", bus.m1_rvalid, mon_r.id);
        chk_w("rsp_data", bus.m1_rvalid ? bus.m1_rdata : bus.m0_rdata, mon_r.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst_b = 1'b1;
    drive_m(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_m(1, 1'b0, 1'b0, 32'd0, 32'd0);
    bus.m0_wstrb = 4'h0; bus.m1_wstrb = 4'h0;
    bus.s_ready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rdata = 32'd0;
    step(); step();
    chk_w("rst_ctrl", {21'd0, bus.m0_ready, bus.m1_ready, bus.m0_rvalid, bus.m1_rvalid,
                       bus.s_req, bus.s_write, bus.err, bus.s_wstrb}, 32'd0);
    chk_w("rst_data", bus.s_addr | bus.s_wdata | bus.m0_rdata | bus.m1_rdata, 32'd0);
    rst_b = 1'b0;
    step();
    chk_b("idle_s_req", bus.s_req, 1'b0);
    bus.s_ready = 1'b1;

    // m1 read, response two cycles after acceptance
    drive_m(1, 1'b1, 1'b0, 32'h100, 32'd0);
    exp_a(1'b1, 1'b0, 32'h100);
    exp_r(1'b1, 32'hDEADBEEF);
    step();
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'd0);
    step();
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'hDEADBEEF;
    #2;
    chk_b("t1_m0_rvalid", bus.m0_rvalid, 1'b0);
    chk_b("t1_m1_rvalid", bus.m1_rvalid, 1'b1);
    chk_b("t1_err", bus.err, 1'b0);
    step();
    bus.s_rvalid = 1'b0;

    // both masters read every cycle from reset: m0,m1,m0,m1
    pulse_reset();
    drive_m(0, 1'b1, 1'b0, 32'h1000, 32'd0);
    drive_m(1, 1'b1, 1'b0, 32'h2000, 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_a(i[0], 1'b0, i[0] ? 32'h2000 : 32'h1000);
    end
    #2;
    chk_b("t2_first_m0", bus.m0_ready, 1'b1);
    step(); step(); step(); step();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'd0);
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_r(i[0], 32'hA0 + 32'(i));
      respond(32'hA0 + 32'(i));
    end

    // fill with four m0 reads, fifth blocks until one pop has registered
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive_m(0, 1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'd0);
      exp_a(1'b0, 1'b0, 32'h10 + 32'(4 * i));
      step();
    end
    drive_m(0, 1'b1, 1'b0, 32'h50, 32'd0);
    exp_a(1'b0, 1'b0, 32'h50);
    #2;
    chk_b("t3_full_s_req", bus.s_req, 1'b0);
    chk_b("t3_full_ready", bus.m0_ready, 1'b0);
    step();
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'hB0;
    exp_r(1'b0, 32'hB0);
    #2;
    chk_b("t3_no_bypass", bus.s_req, 1'b0);
    step();
    bus.s_rvalid = 1'b0;
    #2;
    chk_b("t3_fifth_ready", bus.m0_ready, 1'b1);
    step();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'd0);
    for (int i = 1; i < 5; i++) begin
      exp_r(1'b0, 32'hB0 + 32'(i));
      respond(32'hB0 + 32'(i));
    end

    // full FIFO: a write passes, a granted read stalls everything
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive_m(0, 1'b1, 1'b0, 32'h20 + 32'(4 * i), 32'd0);
      exp_a(1'b0, 1'b0, 32'h20 + 32'(4 * i));
      step();
    end
    drive_m(0, 1'b1, 1'b1, 32'h300, 32'h12345678);
    exp_a(1'b0, 1'b1, 32'h300);
    #2;
    chk_b("t4_wr_ready", bus.m0_ready, 1'b1);
    chk_w("t4_wr_wdata", bus.s_wdata, 32'h12345678);
    step();
    drive_m(0, 1'b1, 1'b0, 32'h310, 32'd0);
    #2;
    chk_b("t4_still_full", bus.s_req, 1'b0);
    step();
    drive_m(0, 1'b1, 1'b1, 32'h320, 32'h55AA55AA);
    drive_m(1, 1'b1, 1'b0, 32'h400, 32'd0);
    #2;
    chk_b("t4_stall_s_req", bus.s_req, 1'b0);
    chk_b("t4_stall_m0", bus.m0_ready, 1'b0);
    chk_b("t4_stall_m1", bus.m1_ready, 1'b0);
    chk_w("t4_hold_addr", bus.s_addr, 32'h400);
    step();
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'hC0;
    exp_r(1'b0, 32'hC0);
    #2;
    chk_b("t4_pop_stall_m1", bus.m1_ready, 1'b0);
    step();
    bus.s_rvalid = 1'b0;
    exp_a(1'b1, 1'b0, 32'h400);
    exp_a(1'b0, 1'b1, 32'h320);
    #2;
    chk_b("t4_m1_go", bus.m1_ready, 1'b1);
    step();
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'd0);
    #2;
    chk_b("t4_m0_wr_go", bus.m0_ready, 1'b1);
    step();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'd0);
    for (int i = 1; i < 4; i++) begin
      exp_r(1'b0, 32'hC0 + 32'(i));
      respond(32'hC0 + 32'(i));
    end
    exp_r(1'b1, 32'hC4);
    respond(32'hC4);

    // in-order routing across masters
    drive_m(0, 1'b1, 1'b0, 32'h500, 32'd0);
    exp_a(1'b0, 1'b0, 32'h500);
    step();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'd0);
    drive_m(1, 1'b1, 1'b0, 32'h600, 32'd0);
    exp_a(1'b1, 1'b0, 32'h600);
    step();
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'd0);
    exp_r(1'b0, 32'h11);
    respond(32'h11);
    exp_r(1'b1, 32'h22);
    respond(32'h22);

    // stray response sets a sticky error
    chk_b("t6_err_before", bus.err, 1'b0);
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'h99;
    #2;
    chk_b("t6_no_m0_rvalid", bus.m0_rvalid, 1'b0);
    chk_b("t6_no_m1_rvalid", bus.m1_rvalid, 1'b0);
    step();
    bus.s_rvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk_b("t6_err_held", bus.err, 1'b1);
      step();
    end
    rst_b = 1'b1;
    #2;
    chk_b("t6_err_cleared", bus.err, 1'b0);
    step();
    rst_b = 1'b0;
    drive_m(0, 1'b1, 1'b0, 32'h700, 32'd0);
    drive_m(1, 1'b1, 1'b0, 32'h800, 32'd0);
    exp_a(1'b0, 1'b0, 32'h700);
    exp_a(1'b1, 1'b0, 32'h800);
    #2;
    chk_b("t6_m0_preferred", bus.m0_ready, 1'b1);
    step(); step();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'd0);
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'd0);
    exp_r(1'b0, 32'h71);
    respond(32'h71);
    exp_r(1'b1, 32'h81);
    respond(32'h81);
    chk_b("t6_err_after_drain", bus.err, 1'b0);

    // reset with a read outstanding discards its ID
    drive_m(1, 1'b1, 1'b0, 32'h900, 32'd0);
    exp_a(1'b1, 1'b0, 32'h900);
    step();
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'd0);
    pulse_reset();
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'h91;
    #2;
    chk_b("t7_dropped_m1", bus.m1_rvalid, 1'b0);
    step();
    bus.s_rvalid = 1'b0;
    #2;
    chk_b("t7_err", bus.err, 1'b1);
    pulse_reset();

    step();
    chk_w("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
    chk_w("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
